control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: microcoded-style sequencer for an 8-bit breadboard CPU.
// States INIT, T0..T4, HALT; every output is a combinational decode of the
// current state, OPCODE and the ALU flags. Datapath strobes are gated by the
// run/step enable, while bus selects always show the decoded source.
// Optional feature: define SINGLE_STEP_EN to add the STEP input, which
// advances one state per synchronized rising edge while RUN=0.
module control_unit (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [3:0] OPCODE,
  input  logic       CF,
  input  logic       ZF,
  input  logic       RUN,
`ifdef SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic       CLR,
  output logic       CE,
  output logic       SU,
  output logic       AIn,
  output logic       BIn,
  output logic       OIn,
  output logic       IIn,
  output logic       FIn,
  output logic       MIn,
  output logic       RI,
  output logic       Jn,
  output logic       DOn,
  output logic       AOn,
  output logic       BOn,
  output logic       IOn,
  output logic       COn,
  output logic       EOn,
  output logic       ROn,
  output logic       NOn,
  output logic       HALTED
);

  typedef enum logic [2:0] {
    S_INIT, S_T0, S_T1, S_T2, S_T3, S_T4, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    B_D, B_A, B_B, B_I, B_C, B_E, B_R, B_N
  } bus_t;

  state_t state_q, state_d;
  bus_t   bus;
  logic   adv;
  logic   step_pulse;
  logic   ce, su, ain, bin, oin, iin, fin, min, ri, jmp;
  logic   last, halt_next;

`ifdef SINGLE_STEP_EN
  logic [2:0] step_sync_q, step_sync_d;

  // Two-flop synchronizer plus a delayed copy for rising-edge detect
  always_comb begin
    step_sync_d = {step_sync_q[1:0], STEP};
  end

  // Step synchronizer registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) step_sync_q <= 3'b000;
    else         step_sync_q <= step_sync_d;
  end

  assign step_pulse = step_sync_q[1] & ~step_sync_q[2];
`else
  assign step_pulse = 1'b0;
`endif

  // A state advances (and its strobes fire) when free-running or on a step
  assign adv = RUN | step_pulse;

  // Decode the current step into a bus source, raw strobes and sequencing
  always_comb begin
    bus       = B_D;
    ce        = 1'b0;
    su        = 1'b0;
    ain       = 1'b0;
    bin       = 1'b0;
    oin       = 1'b0;
    iin       = 1'b0;
    fin       = 1'b0;
    min       = 1'b0;
    ri        = 1'b0;
    jmp       = 1'b0;
    last      = 1'b0;
    halt_next = 1'b0;
    case (state_q)
      S_T0: begin
        bus = B_C;
        min = 1'b1;
      end
      S_T1: begin
        bus = B_R;
        iin = 1'b1;
        ce  = 1'b1;
        // NOP and the unused A-D opcodes have no execute steps
        last = (OPCODE == 4'h0) || (OPCODE >= 4'hA && OPCODE <= 4'hD);
      end
      S_T2: begin
        case (OPCODE)
          4'h1, 4'h2, 4'h3, 4'h4: begin bus = B_I; min = 1'b1; end
          4'h5: begin bus = B_I; ain = 1'b1; last = 1'b1; end
          4'h6: begin bus = B_I; jmp = 1'b1; last = 1'b1; end
          4'h7: begin bus = B_I; jmp = CF;   last = 1'b1; end
          4'h8: begin bus = B_I; jmp = ZF;   last = 1'b1; end
          4'h9: begin bus = B_N; ain = 1'b1; last = 1'b1; end
          4'hE: begin bus = B_A; oin = 1'b1; last = 1'b1; end
          4'hF: halt_next = 1'b1;
          default: last = 1'b1;
        endcase
      end
      S_T3: begin
        case (OPCODE)
          4'h1:       begin bus = B_R; ain = 1'b1; last = 1'b1; end
          4'h2, 4'h3: begin bus = B_R; bin = 1'b1; end
          4'h4:       begin bus = B_A; ri  = 1'b1; last = 1'b1; end
          default:    last = 1'b1;
        endcase
      end
      S_T4: begin
        last = 1'b1;
        if (OPCODE == 4'h2 || OPCODE == 4'h3) begin
          bus = B_E;
          ain = 1'b1;
          fin = 1'b1;
          su  = (OPCODE == 4'h3);
        end
      end
      default: ;
    endcase
  end

  // Next-state selection; HALT is left only through reset
  always_comb begin
    state_d = state_q;
    if (adv) begin
      case (state_q)
        S_INIT: state_d = S_T0;
        S_T0:   state_d = S_T1;
        S_T1:   state_d = last ? S_T0 : S_T2;
        S_T2:   state_d = halt_next ? S_HALT : (last ? S_T0 : S_T3);
        S_T3:   state_d = last ? S_T0 : S_T4;
        S_T4:   state_d = S_T0;
        S_HALT: state_d = S_HALT;
        default: state_d = S_INIT;
      endcase
    end
  end

  // State register; reset forces INIT at once, even mid-instruction
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  // CLR follows INIT directly so the datapath is cleared while held in reset
  assign CLR    = (state_q == S_INIT);
  assign HALTED = (state_q == S_HALT);
  assign CE     = ce  & adv;
  assign SU     = su  & adv;
  assign AIn    = ain & adv;
  assign BIn    = bin & adv;
  assign OIn    = oin & adv;
  assign IIn    = iin & adv;
  assign FIn    = fin & adv;
  assign MIn    = min & adv;
  assign RI     = ri  & adv;
  assign Jn     = ~(jmp & adv);

  // Exactly one active-low bus source, ungated so the bus stays defined
  assign DOn = (bus != B_D);
  assign AOn = (bus != B_A);
  assign BOn = (bus != B_B);
  assign IOn = (bus != B_I);
  assign COn = (bus != B_C);
  assign EOn = (bus != B_E);
  assign ROn = (bus != B_R);
  assign NOn = (bus != B_N);

endmodule
